// File: rtl/spi_pkg.sv
// ============================================================================
//  Module      : spi_pkg
//  Description : Shared state encoding, command codes and counter-load helper
//                for the SPI master.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEAD  = 3'd1,
    SEL   = 3'd2,
    SHIFT = 3'd3,
    TURN  = 3'd4,
    RECV  = 3'd5,
    GAP   = 3'd6
  } spi_state_t;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  // Bit-counter reload value on entry to a state: its dwell time minus one.
  function automatic logic [3:0] f_cnt_load(input spi_state_t s,
                                            input int shift_len,
                                            input int turn_len,
                                            input int recv_len,
                                            input int gap_len);
    int n;
    case (s)
      SHIFT:   n = shift_len;
      TURN:    n = turn_len;
      RECV:    n = recv_len;
      GAP:     n = gap_len;
      default: n = 1;
    endcase
    return 4'(n - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_master_if.sv
// ============================================================================
//  Module      : spi_master_if
//  Description : Request/response handshake and SPI pin bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface spi_master_if #(
  parameter int ADDR_SIZE = 8
) ();
  logic                 req_valid;
  logic                 req_ready;
  logic [1:0]           req_cmd;
  logic [ADDR_SIZE-1:0] req_data;
  logic                 busy;
  logic [ADDR_SIZE-1:0] rx_data;
  logic                 rx_valid;
  logic                 MISO;
  logic                 MOSI;
  logic                 ss_n;

  modport master (
    input  req_valid, req_cmd, req_data, MISO,
    output req_ready, busy, rx_data, rx_valid, MOSI, ss_n
  );

  modport slave (
    output req_valid, req_cmd, req_data, MISO,
    input  req_ready, busy, rx_data, rx_valid, MOSI, ss_n
  );
endinterface

`default_nettype wire

// File: rtl/spi_master_sync2.sv
// ============================================================================
//  Module      : spi_sync2
//  Description : Two-flop MISO synchronizer, used when SPI_MASTER_MISO_SYNC_EN
//                is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_sync2 (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_d,
  output logic      o_q
);
  logic r_meta;
  logic r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;
endmodule

`default_nettype wire

// File: rtl/spi_master.sv
// ============================================================================
//  Module      : spi_master
//  Description : Single-clock SPI master issuing {cmd,payload} frames and
//                capturing read-data replies. Optional MISO synchronizer
//                enabled by SPI_MASTER_MISO_SYNC_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_master #(
  parameter int ADDR_SIZE  = 8,
  parameter int RD_WAIT    = 1,
  parameter int GAP_CYCLES = 1
) (
  input  wire logic   clk,
  input  wire logic   rst,
  spi_master_if.master bus
);
  import spi_pkg::*;

  localparam int c_FRAME_BITS = ADDR_SIZE + 2;

  logic w_miso;
`ifdef SPI_MASTER_MISO_SYNC_EN
  localparam int c_SYNC_LAT = 2;
  spi_sync2 u_sync2 (
    .clk (clk),
    .rst (rst),
    .i_d (bus.MISO),
    .o_q (w_miso)
  );
`else
  localparam int c_SYNC_LAT = 0;
  assign w_miso = bus.MISO;
`endif

  localparam int c_TURN_LEN = RD_WAIT + c_SYNC_LAT;

  spi_state_t              r_state;
  spi_state_t              w_state_nxt;
  logic [3:0]              r_cnt;
  logic [c_FRAME_BITS-1:0] r_tx;
  logic [1:0]              r_cmd;
  logic                    r_ss_n;
  logic                    r_mosi;
  logic                    r_rx_en;
  logic                    r_rx_last;
  logic [ADDR_SIZE-2:0]    r_rx_sh;
  logic [ADDR_SIZE-1:0]    r_rx_data;
  logic                    r_rx_valid;
  logic                    w_ready;
  logic                    w_accept;
  logic                    w_ss_n_nxt;
  logic                    w_mosi_nxt;

  assign w_ready = (r_state == IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Pins are registered from the current state, so each state's levels
  // appear on the bus one cycle after the state is entered.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_ss_n_nxt  = (r_state == IDLE) || (r_state == GAP);
    w_mosi_nxt  = ((r_state == SEL) || (r_state == SHIFT)) ? r_tx[c_FRAME_BITS-1] : 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.req_valid && w_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = LEAD;
        end
      end
      LEAD:  w_state_nxt = SEL;
      SEL:   w_state_nxt = SHIFT;
      SHIFT: begin
        if (r_cnt == 4'd0) begin
          if (r_cmd == CMD_RD_DATA) w_state_nxt = (c_TURN_LEN == 0) ? RECV : TURN;
          else                      w_state_nxt = GAP;
        end
      end
      TURN:    if (r_cnt == 4'd0) w_state_nxt = RECV;
      RECV:    if (r_cnt == 4'd0) w_state_nxt = GAP;
      GAP:     if (r_cnt == 4'd0) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ss_n     <= 1'b1;
      r_mosi     <= 1'b0;
      r_cnt      <= 4'd0;
      r_tx       <= '0;
      r_cmd      <= 2'b00;
      r_rx_en    <= 1'b0;
      r_rx_last  <= 1'b0;
      r_rx_sh    <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
    end else begin
      r_ss_n     <= w_ss_n_nxt;
      r_mosi     <= w_mosi_nxt;
      r_rx_valid <= 1'b0;
      r_rx_en    <= (r_state == RECV);
      r_rx_last  <= (r_state == RECV) && (r_cnt == 4'd0);

      if (w_accept) begin
        r_tx  <= {bus.req_cmd, bus.req_data};
        r_cmd <= bus.req_cmd;
      end else if (r_state == SHIFT) begin
        r_tx <= {r_tx[c_FRAME_BITS-2:0], 1'b0};
      end

      if (w_state_nxt != r_state)
        r_cnt <= f_cnt_load(w_state_nxt, c_FRAME_BITS, c_TURN_LEN, ADDR_SIZE, GAP_CYCLES);
      else if (r_cnt != 4'd0)
        r_cnt <= r_cnt - 4'd1;

      // Sampling trails RECV by one cycle to line up with the registered pins.
      if (r_rx_en)
        r_rx_sh <= {r_rx_sh[ADDR_SIZE-3:0], w_miso};
      if (r_rx_last) begin
        r_rx_data  <= {r_rx_sh, w_miso};
        r_rx_valid <= 1'b1;
      end
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.busy      = (r_state != IDLE);
  assign bus.rx_data   = r_rx_data;
  assign bus.rx_valid  = r_rx_valid;
  assign bus.MOSI      = r_mosi;
  assign bus.ss_n      = r_ss_n;
endmodule

`default_nettype wire

// File: doc/spi_master.md
# spi_master

- Single-clock SPI master that issues command frames to the SPI slave + single-port RAM wrapper over MOSI/MISO/ss_n.
- Lets on-chip logic (sequencer, CPU bridge, test driver) read and write the slave RAM without a bit-banging testbench.
- Accepts one request per valid/ready handshake: 2-bit command + 8-bit payload.
- Serializes the frame in the slave's expected format; for read-data frames, deserializes the 8-bit reply and returns it with a one-cycle valid pulse.

## Interface
Parameters:
- ADDR_SIZE, 8, payload width (address/data byte)
- RD_WAIT, 1, cycles between last payload bit and first MISO sample on read-data frames
- GAP_CYCLES, 1, minimum ss_n-high cycles between frames (>=1)

Ports:
- clk  in  1  system clock; also the SPI bit clock. All logic is on the rising edge.
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE and only while rst is low
- req_cmd  in  2  00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data
- req_data  in  ADDR_SIZE  payload, sent MSB first
- busy  out  1  high whenever state != IDLE
- rx_data  out  ADDR_SIZE  last read-data reply; holds until the next reply
- rx_valid  out  1  one-cycle pulse when rx_data updates
- MISO  in  1  slave serial out
- MOSI  out  1  registered serial out
- ss_n  out  1  registered active-low slave select

## Operation
- A request is accepted on an edge where req_valid && req_ready. cmd and data are captured into a 10-bit shift register {cmd, data}.
- States and transitions:
  - IDLE -> LEAD on acceptance
  - LEAD (1 cycle) -> SEL (1 cycle) -> SHIFT (10 cycles)
  - SHIFT -> TURN if cmd==11, else -> GAP
  - TURN (RD_WAIT cycles) -> RECV (8 cycles) -> GAP
  - GAP (GAP_CYCLES) -> IDLE
- Outputs per state:
  - LEAD: ss_n=0, MOSI=0
  - SEL: ss_n=0, MOSI=cmd[1] (slave read/write select)
  - SHIFT: MOSI = shift-register MSB each cycle, giving the order cmd[1], cmd[0], data[7]..data[0]
  - TURN, RECV: MOSI=0
  - GAP, IDLE: ss_n=1, MOSI=0
- RECV samples MISO once per cycle into the rx shift register, MSB first.
- Bit counter is 4 bits; it reloads on every state entry and never wraps within a state.
- req_valid is ignored while busy. There is no queueing.
- Reset: ss_n=1, MOSI=0, rx_valid=0, rx_data=0, busy=0, state=IDLE. While rst is high, req_ready=0.
- Reset mid-frame takes effect on the next edge: ss_n rises, the frame is abandoned, and no rx_valid is produced.

## Timing
- Acceptance at edge k:
  - ss_n low from edge k+1.
  - SEL bit on MOSI during cycle k+2.
  - Payload bits during cycles k+3..k+12.
- Write and rd-addr frames:
  - ss_n low for exactly 12 cycles, then high for GAP_CYCLES.
  - req_ready returns at k+13+GAP_CYCLES, so back-to-back requests have a period of 12+GAP_CYCLES+1.
- Read-data frame:
  - ss_n low for 12+RD_WAIT+8 cycles (21 by default).
  - MISO is sampled on the 8 edges ending at ss_n deassertion.
  - rx_valid pulses the cycle ss_n rises, with rx_data already valid in that cycle.
- MOSI and ss_n change only on clk rising edges. The slave samples them on the following edge.

## Configuration
- SPI_MASTER_MISO_SYNC_EN defined:
  - MISO passes through a 2-flop synchronizer before sampling.
  - The RECV window shifts 2 cycles later (ss_n low 23 cycles by default).
  - rx_valid timing relative to ss_n rising is unchanged.
- Undefined: MISO is sampled directly; timing is as stated above.

## Structure
- Shared package spi_pkg holds:
  - state encoding: IDLE, LEAD, SEL, SHIFT, TURN, RECV, GAP
  - command codes: CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11
- One sub-module: spi_sync2, the MISO synchronizer. It is instantiated only under SPI_MASTER_MISO_SYNC_EN.

## Test plan
1. Wr-addr, req_data=0x5A:
   - MOSI over ss_n-low cycles = 0,0,0,0,0,1,0,1,1,0,1,0
   - ss_n low exactly 12 cycles
   - no rx_valid
2. Wr-data 0xC3 to the real slave, then rd-addr 0x5A, then rd-data:
   - rx_valid once, with rx_data=0xC3
3. Rd-data with MISO driven by a bench model returning 0xA5 in the RECV window:
   - ss_n low 21 cycles
   - rx_data=0xA5 in the cycle ss_n rises
4. req_valid held high for 3 wr-data requests:
   - exactly 3 frames
   - ss_n high ≥ GAP_CYCLES between frames
   - req_ready low throughout each frame
5. rst asserted at payload bit 5 of a rd-data frame:
   - next edge: ss_n=1, MOSI=0, busy=0
   - no rx_valid
   - the next request then runs normally
6. With SPI_MASTER_MISO_SYNC_EN defined, scenario 3 is repeated:
   - ss_n low 23 cycles
   - rx_data=0xA5
